// File: rtl/step_seq_pkg.sv
// Shared types and helpers for the one-hot control-step sequencer.
package step_seq_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Widest step vector the onehot() helper can produce.
  localparam int MAX_STEPS = 64;

  // Index width for the default six-step configuration; each sequencer
  // instance derives its own from NUM_STEPS.
  localparam int DEF_NUM_STEPS = 6;
  localparam int DEF_IDX_W     = $clog2(DEF_NUM_STEPS);

  // One-hot step vector for step idx out of n; all-zero when idx is out of range.
  function automatic logic [MAX_STEPS-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_STEPS-1:0] v;
    v = '0;
    if (idx < n && idx < MAX_STEPS) v = MAX_STEPS'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// Wrapping instruction-cycle counter: sync clear beats increment strobe.
module seq_cycle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, else wrap-around increment on strobe.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/step_sequencer.sv
// One-hot control-step sequencer with overflow halt, stall, sync restart
// and completed-instruction counter.
// Optional feature: define STEP_SKIP_EN to add the SKIP input (early return
// to step 0, counted as a completed instruction).
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int NUM_STEPS = 6,
  parameter int OVF_STEP  = 5,
  parameter int CNT_W     = 8
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         CLR,
  input  logic                         EN,
  input  logic                         OVERFLOW,
`ifdef STEP_SKIP_EN
  input  logic                         SKIP,
`endif
  output logic [NUM_STEPS-1:0]         STEP,
  output logic [$clog2(NUM_STEPS)-1:0] STEP_IDX,
  output logic                         HALTED,
  output logic [CNT_W-1:0]             INSTR_CNT
);

  localparam int IDX_W = $clog2(NUM_STEPS);
  localparam logic [IDX_W-1:0] OVF_IDX  = IDX_W'(OVF_STEP);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

  state_e                state_q, state_d;
  logic [NUM_STEPS-1:0]  step_q, step_d, step_chk;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  illegal;
  logic                  cnt_inc;

  // Next-state logic. Step vector and index are both registered so every
  // output comes straight from a flop; the one-hot vector is rebuilt from
  // the next index so the two can only disagree after an upset, which is
  // caught by the illegal check and steered back to step 0.
  always_comb begin
    step_chk = NUM_STEPS'(onehot(32'(idx_q), NUM_STEPS));
    // step_chk is zero when idx_q is out of range, so that case is illegal too.
    illegal  = (step_q != step_chk) || (step_chk == '0);
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_inc  = 1'b0;
    if (CLR) begin
      state_d = ST_RUN;
      idx_d   = '0;
    end else if (state_q == ST_HALT) begin
      idx_d   = '0;
    end else if (illegal) begin
      idx_d   = '0;
    end else if (EN) begin
      if (idx_q == OVF_IDX && OVERFLOW) begin
        state_d = ST_HALT;
        idx_d   = '0;
      end
`ifdef STEP_SKIP_EN
      else if (SKIP) begin
        idx_d   = '0;
        cnt_inc = 1'b1;
      end
`endif
      else if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        cnt_inc = 1'b1;
      end else begin
        idx_d   = idx_q + 1'b1;
      end
    end
    step_d = (state_d == ST_RUN) ? NUM_STEPS'(onehot(32'(idx_d), NUM_STEPS)) : '0;
  end

  // State, step vector and index registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_RUN;
      step_q  <= NUM_STEPS'(1);
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
    end
  end

  seq_cycle_counter #(.W(CNT_W)) u_cnt (
    .clk (CLK),
    .rst (RESET),
    .clr (CLR),
    .inc (cnt_inc),
    .cnt (INSTR_CNT)
  );

  assign STEP     = step_q;
  assign STEP_IDX = idx_q;
  assign HALTED   = (state_q == ST_HALT);

endmodule
